// File: rtl/sd_sched_pkg.sv
// Shared types and helpers for the SD RAM block scheduler.
package sd_sched_pkg;

    typedef enum logic [1:0] {BUS_IDLE, BUS_FILL, BUS_DRAIN} bus_st_t;
    typedef enum logic       {PROC_IDLE, PROC_BUSY}          proc_st_t;

    localparam int NBLK_DEF = 8;

    // Ring pointers carry one extra wrap bit so full and empty differ.
    function automatic int ptr_w(input int nblk);
        return $clog2(nblk) + 1;
    endfunction

endpackage

// File: rtl/sd_blk_ptr.sv
// Wrap counter for one ring pointer; clear beats increment.
module sd_blk_ptr #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PW'(1);
    end

endmodule

// File: rtl/sd_blk_sched.sv
// Block scheduler for the SD <-> cipher RAM ring: FREE -> FILLED -> PROCESSED -> FREE.
// Define SD_SCHED_RR_EN for round-robin fill/drain arbitration (default: drain priority).
module sd_blk_sched
    import sd_sched_pkg::*;
#(
    parameter int NBLK = NBLK_DEF,
    parameter int BW   = ptr_w(NBLK) - 1
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          iclr,
    input  logic          ireq_fill,
    output logic          ofill_grant,
    output logic [BW-1:0] ofill_blk,
    input  logic          ifill_done,
    input  logic          ireq_proc,
    output logic          oproc_grant,
    output logic [BW-1:0] oproc_blk,
    input  logic          iproc_done,
    input  logic          ireq_drain,
    output logic          odrain_grant,
    output logic [BW-1:0] odrain_blk,
    input  logic          idrain_done,
    output logic [BW:0]   ofree_cnt,
    output logic          ofull,
    output logic          oempty
);

    localparam int PW = BW + 1;

    bus_st_t       bus_st;
    proc_st_t      proc_st;
    logic [PW-1:0] fptr, pptr, dptr, occ;
    logic          fill_inc, proc_inc, drain_inc;
    logic          fill_req, proc_req, drain_req, pick_drain;

    // Dones only count while the matching grant is held.
    assign fill_inc  = (bus_st == BUS_FILL)   && ifill_done;
    assign drain_inc = (bus_st == BUS_DRAIN)  && idrain_done;
    assign proc_inc  = (proc_st == PROC_BUSY) && iproc_done;

    sd_blk_ptr #(.PW(PW)) u_fptr (.clk(iclk), .rst_n(irst_n), .clr(iclr), .inc(fill_inc),  .ptr(fptr));
    sd_blk_ptr #(.PW(PW)) u_pptr (.clk(iclk), .rst_n(irst_n), .clr(iclr), .inc(proc_inc),  .ptr(pptr));
    sd_blk_ptr #(.PW(PW)) u_dptr (.clk(iclk), .rst_n(irst_n), .clr(iclr), .inc(drain_inc), .ptr(dptr));

    assign occ       = fptr - dptr;
    assign fill_req  = ireq_fill  && (occ < PW'(NBLK));
    assign proc_req  = ireq_proc  && (pptr != fptr);
    assign drain_req = ireq_drain && (dptr != pptr);

    assign ofree_cnt = PW'(NBLK) - occ;
    assign ofull     = (occ == PW'(NBLK));
    assign oempty    = (occ == '0) && !ofill_grant && !oproc_grant && !odrain_grant;

`ifdef SD_SCHED_RR_EN
    logic fill_pri;

    assign pick_drain = drain_req && !(fill_req && fill_pri);

    // Last-winner flag: after a drain win, fill gets the next tie.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)
            fill_pri <= 1'b0;
        else if (iclr)
            fill_pri <= 1'b0;
        else if (bus_st == BUS_IDLE && (drain_req || fill_req))
            fill_pri <= pick_drain;
    end
`else
    assign pick_drain = drain_req;
`endif

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n || iclr) begin
            bus_st       <= BUS_IDLE;
            ofill_grant  <= 1'b0;
            odrain_grant <= 1'b0;
            ofill_blk    <= '0;
            odrain_blk   <= '0;
        end else begin
            case (bus_st)
                BUS_IDLE: begin
                    if (pick_drain) begin
                        bus_st       <= BUS_DRAIN;
                        odrain_grant <= 1'b1;
                        odrain_blk   <= dptr[BW-1:0];
                    end else if (fill_req) begin
                        bus_st      <= BUS_FILL;
                        ofill_grant <= 1'b1;
                        ofill_blk   <= fptr[BW-1:0];
                    end
                end
                BUS_FILL: if (ifill_done) begin
                    bus_st      <= BUS_IDLE;
                    ofill_grant <= 1'b0;
                end
                BUS_DRAIN: if (idrain_done) begin
                    bus_st       <= BUS_IDLE;
                    odrain_grant <= 1'b0;
                end
                default: begin
                    bus_st       <= BUS_IDLE;
                    ofill_grant  <= 1'b0;
                    odrain_grant <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n || iclr) begin
            proc_st     <= PROC_IDLE;
            oproc_grant <= 1'b0;
            oproc_blk   <= '0;
        end else begin
            case (proc_st)
                PROC_IDLE: if (proc_req) begin
                    proc_st     <= PROC_BUSY;
                    oproc_grant <= 1'b1;
                    oproc_blk   <= pptr[BW-1:0];
                end
                PROC_BUSY: if (iproc_done) begin
                    proc_st     <= PROC_IDLE;
                    oproc_grant <= 1'b0;
                end
                default: begin
                    proc_st     <= PROC_IDLE;
                    oproc_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_blk_sched.sv
// Randomized scoreboard bench for sd_blk_sched against a per-block state model.
module tb_sd_blk_sched;

    localparam int NB = 8;
    localparam int BW = 3;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          iclr = 1'b0;
    logic          ireq_fill = 1'b0, ifill_done = 1'b0;
    logic          ireq_proc = 1'b0, iproc_done = 1'b0;
    logic          ireq_drain = 1'b0, idrain_done = 1'b0;
    logic          ofill_grant, oproc_grant, odrain_grant;
    logic [BW-1:0] ofill_blk, oproc_blk, odrain_blk;
    logic [BW:0]   ofree_cnt;
    logic          ofull, oempty;

    sd_blk_sched #(.NBLK(NB)) dut (
        .iclk(iclk), .irst_n(irst_n), .iclr(iclr),
        .ireq_fill(ireq_fill), .ofill_grant(ofill_grant), .ofill_blk(ofill_blk), .ifill_done(ifill_done),
        .ireq_proc(ireq_proc), .oproc_grant(oproc_grant), .oproc_blk(oproc_blk), .iproc_done(iproc_done),
        .ireq_drain(ireq_drain), .odrain_grant(odrain_grant), .odrain_blk(odrain_blk), .idrain_done(idrain_done),
        .ofree_cnt(ofree_cnt), .ofull(ofull), .oempty(oempty)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int fg, fb, pg, pb, dg, db, fc, full, empty;
    } exp_t;

    typedef enum int {B_FREE, B_FILLED, B_PROC} bst_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: each block's life-cycle state plus next index per agent.
    bst_t bst[NB];
    int   fi, pi, di, bf, bp, bd;
    bit   gf, gp, gd;
`ifdef SD_SCHED_RR_EN
    bit   pref_fill;
`endif

    task automatic model_step(input bit rst_n, input bit clr,
                              input bit rf, input bit fd, input bit rp,
                              input bit pd, input bit rd, input bit dd);
        bst_t old[NB];
        bit   ef, ep, ed, drain_wins;
        exp_t e;
        int   nfree;
        if (!rst_n || clr) begin
            foreach (bst[i]) bst[i] = B_FREE;
            fi = 0; pi = 0; di = 0; bf = 0; bp = 0; bd = 0;
            gf = 0; gp = 0; gd = 0;
`ifdef SD_SCHED_RR_EN
            pref_fill = 0;
`endif
        end else begin
            old = bst;
            ef = rf && old[fi] == B_FREE;
            ep = rp && old[pi] == B_FILLED;
            ed = rd && old[di] == B_PROC;
            if (gp) begin
                if (pd) begin bst[pi] = B_PROC; pi = (pi + 1) % NB; gp = 0; end
            end else if (ep) begin
                gp = 1; bp = pi;
            end
            if (gf) begin
                if (fd) begin bst[fi] = B_FILLED; fi = (fi + 1) % NB; gf = 0; end
            end else if (gd) begin
                if (dd) begin bst[di] = B_FREE; di = (di + 1) % NB; gd = 0; end
            end else if (ef || ed) begin
`ifdef SD_SCHED_RR_EN
                drain_wins = ed && !(ef && pref_fill);
                pref_fill = drain_wins;
`else
                drain_wins = ed;
`endif
                if (drain_wins) begin gd = 1; bd = di; end
                else begin gf = 1; bf = fi; end
            end
        end
        nfree = 0;
        foreach (bst[i]) if (bst[i] == B_FREE) nfree++;
        e.fg = gf; e.fb = bf; e.pg = gp; e.pb = bp; e.dg = gd; e.db = bd;
        e.fc = nfree; e.full = (nfree == 0);
        e.empty = (nfree == NB) && !gf && !gp && !gd;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every cycle's registered outputs with the model's prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge iclk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fill_grant",  int'(ofill_grant),  e.fg);
                chk("proc_grant",  int'(oproc_grant),  e.pg);
                chk("drain_grant", int'(odrain_grant), e.dg);
                chk("fill_blk",    int'(ofill_blk),    e.fb);
                chk("proc_blk",    int'(oproc_blk),    e.pb);
                chk("drain_blk",   int'(odrain_blk),   e.db);
                chk("free_cnt",    int'(ofree_cnt),    e.fc);
                chk("full",        int'(ofull),        e.full);
                chk("empty",       int'(oempty),       e.empty);
                chk("bus_excl",    int'(ofill_grant && odrain_grant), 0);
            end
        end
    end

    function automatic bit pct(input int p);
        return ($urandom % 100) < p;
    endfunction

    task automatic drive(input bit rst_n, input int pf, input int pp, input int pdr, input int pclr);
        @(negedge iclk);
        irst_n      = rst_n;
        iclr        = pct(pclr);
        ireq_fill   = pct(pf);
        ireq_proc   = pct(pp);
        ireq_drain  = pct(pdr);
        ifill_done  = gf ? pct(35) : pct(5);
        iproc_done  = gp ? pct(35) : pct(5);
        idrain_done = gd ? pct(35) : pct(5);
        model_step(irst_n, iclr, ireq_fill, ifill_done, ireq_proc,
                   iproc_done, ireq_drain, idrain_done);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b0, 50, 50, 50, 0);
        // Fill-heavy: drives the ring to full and holds pending fills there.
        for (int i = 0; i < 400; i++)  drive(1'b1, 95, 5, 5, 0);
        // Mixed traffic with contention, wrap-around and occasional flushes.
        for (int i = 0; i < 3000; i++) drive(1'b1, 70, 70, 70, 1);
        // Drain-heavy: walks the ring back to empty.
        for (int i = 0; i < 600; i++)  drive(1'b1, 5, 90, 95, 0);
        // Full contention, no flushes.
        for (int i = 0; i < 2000; i++) drive(1'b1, 100, 100, 100, 0);
        for (int i = 0; i < 300; i++)  drive(1'b1, 0, 100, 100, 0);
        @(negedge iclk);
        ireq_fill = 0; ireq_proc = 0; ireq_drain = 0;
        ifill_done = 0; iproc_done = 0; idrain_done = 0; iclr = 0;
        repeat (3) @(posedge iclk);
        #2;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain cycle=%0d actual=%0d expected=0", cyc, sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
